nco_phase_acc: RTL and testbench
================================

NCO_PHASE_ACC -- requirements
Module: nco_phase_acc

Interface
REQ-001 Parameter VOICES, default 8, number of time-multiplexed voices (power of two, 2..16).
REQ-002 Parameter PHASE_W, default 24, width of each phase accumulator; the 16-bit step is zero-extended to PHASE_W before addition.
REQ-003 Parameter OUT_W, default 12, number of phase MSBs presented on out_phase.
REQ-004 Port clk, input, 1, sole clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1, reset: asynchronous, active-low.
REQ-006 Port sample_tick, input, 1, one-cycle pulse that starts one scan over all voices.
REQ-007 Port note_we, input, 1, write strobe for the voice configuration.
REQ-008 Port note_voice, input, clog2(VOICES), voice index for the write.
REQ-009 Port note_num, input, 7, MIDI note number for the write.
REQ-010 Port note_gate, input, 1, gate for the write (1 = sounding).
REQ-011 Port note_retrig, input, 1, when set with note_we, clears that voice's phase.
REQ-012 Port rom_ce, output, 1, read enable to the step-size ROM.
REQ-013 Port rom_a, output, 7, note address to the step-size ROM.
REQ-014 Port rom_d, input, 16, step size returned by the ROM exactly one clk after rom_ce.
REQ-015 Port out_valid, output, 1, per-voice phase sample available.
REQ-016 Port out_ready, input, 1, downstream accept.
REQ-017 Port out_voice, output, clog2(VOICES), voice index of the current sample.
REQ-018 Port out_phase, output, OUT_W, phase[PHASE_W-1 -: OUT_W] after the update.
REQ-019 Port out_gate, output, 1, gate of the voice.
REQ-020 Port overrun, output, 1, sticky flag: a tick was dropped.

Function
REQ-021 Per-voice state is note (7 b), gate (1 b) and phase (PHASE_W b), held in registers.
REQ-022 The FSM states are IDLE, ADDR and ACC.
REQ-023 IDLE -> ADDR on sample_tick; the voice counter is set to 0.
REQ-024 In ADDR, rom_ce=1 and rom_a=note[vcnt] for exactly one cycle; the next state is ACC.
REQ-025 In ACC, out_valid=1, out_voice=vcnt, out_gate=gate[vcnt], and out_phase=MSBs of (phase+rom_d) mod 2^PHASE_W when gate=1, or 0 when gate=0.
REQ-026 The ACC sample is combinationally derived from the registered rom_d capture; rom_d is registered on entry to ACC so that it is held stable while out_ready=0.
REQ-027 The ACC handshake completes when out_valid=1 and out_ready=1. On completion, phase[vcnt] takes the new value (0 if gate=0), then the FSM goes to ADDR with vcnt+1, or to IDLE if vcnt=VOICES-1.
REQ-028 Under backpressure (out_ready=0 in ACC), all outputs are held stable and the phase is not written.
REQ-029 Minimum scan length is 2*VOICES cycles; the first out_valid is 2 cycles after sample_tick.
REQ-030 A sample_tick arriving outside IDLE is dropped and sets overrun=1; overrun clears only on reset.
REQ-031 note_we writes note, gate and (if note_retrig) phase=0 for note_voice in any state.
REQ-032 A note write to the voice in ADDR takes effect from the next scan (rom_a already issued).
REQ-033 If a retrig and an ACC completion hit the same voice in the same cycle, the retrig wins (phase=0).
REQ-034 Phase wraps modulo 2^PHASE_W with no saturation or flag.

Reset
REQ-035 While rst_n=0: FSM=IDLE, vcnt=0, all phase=0, note=0, gate=0, and overrun=0.
REQ-036 While rst_n=0: rom_ce=0, rom_a=0, out_valid=0, out_voice=0, out_phase=0 and out_gate=0.
REQ-037 Reset asserted mid-scan aborts the scan immediately; the first scan after release needs a fresh sample_tick.

Structure
REQ-038 A shared package nco_pkg holds NOTE_W=7, STEP_W=16 and the FSM state encoding.
REQ-039 nco_phase_acc instantiates no sub-modules; step_size_rom is instantiated beside it at the level above, with rom_* wired directly.

Verification
REQ-040 Voice 0 is note 69 with gate on, out_ready=1; 3 ticks -> the voice-0 phases are 901, 1802 and 2703 (out_phase = the 12 MSBs of each).
REQ-041 Voice 3 is note 127 with gate on; 654 ticks -> phase 24044 (wrapped once).
REQ-042 out_ready held low for 5 cycles in ACC of voice 2 -> outputs stay stable, then exactly one update is applied and the scan completes.
REQ-043 A second sample_tick 3 cycles after the first -> overrun=1 and the scan is unaffected (VOICES samples emitted).
REQ-044 A retrig write to voice 1 in the same cycle as its ACC completion -> phase[1]=0; a gate-off voice emits out_gate=0, out_phase=0.
REQ-045 rst_n pulsed low during ACC of voice 4 -> all outputs return to 0 asynchronously, and no out_valid appears until the next tick.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared widths and FSM state encoding for the time-multiplexed NCO
// phase accumulator.
package nco_pkg;

    localparam int NOTE_W = 7;
    localparam int STEP_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        ACC  = 2'd2
    } state_t;

endpackage

// File: rtl/nco_phase_acc.sv
// Time-multiplexed NCO phase accumulator. Each sample_tick scans every voice,
// fetching its step size from an external synchronous ROM, and emits one phase sample per voice.
module nco_phase_acc
    import nco_pkg::*;
#(
    parameter int VOICES  = 8,
    parameter int PHASE_W = 24,
    parameter int OUT_W   = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sample_tick,
    input  logic                      note_we,
    input  logic [$clog2(VOICES)-1:0] note_voice,
    input  logic [NOTE_W-1:0]         note_num,
    input  logic                      note_gate,
    input  logic                      note_retrig,
    output logic                      rom_ce,
    output logic [NOTE_W-1:0]         rom_a,
    input  logic [STEP_W-1:0]         rom_d,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(VOICES)-1:0] out_voice,
    output logic [OUT_W-1:0]          out_phase,
    output logic                      out_gate,
    output logic                      overrun
);

    localparam int VW = $clog2(VOICES);

    state_t              r_state;
    state_t              w_nextState;
    logic [VW-1:0]       r_vcnt;
    logic [VW-1:0]       w_nextVcnt;
    logic [NOTE_W-1:0]   r_note  [VOICES];
    logic [PHASE_W-1:0]  r_phase [VOICES];
    logic [VOICES-1:0]   r_gate;
    logic [STEP_W-1:0]   r_step;
    logic                r_first;
    logic                r_overrun;

    logic [STEP_W-1:0]   w_step;
    logic [PHASE_W-1:0]  w_sum;
    logic [PHASE_W-1:0]  w_newPhase;
    logic                w_done;

    // ROM data is live only in the first ACC cycle; later stall cycles use the captured copy.
    assign w_step     = r_first ? rom_d : r_step;
    assign w_sum      = r_phase[r_vcnt] + PHASE_W'(w_step);
    assign w_newPhase = r_gate[r_vcnt] ? w_sum : '0;
    assign w_done     = (r_state == ACC) && out_ready;
    assign overrun    = r_overrun;

    always_comb begin
        w_nextState = r_state;
        w_nextVcnt  = r_vcnt;
        case (r_state)
            IDLE: begin
                if (sample_tick) begin
                    w_nextState = ADDR;
                    w_nextVcnt  = '0;
                end
            end
            ADDR: w_nextState = ACC;
            ACC: begin
                if (out_ready) begin
                    if (r_vcnt == VW'(VOICES - 1)) begin
                        w_nextState = IDLE;
                    end else begin
                        w_nextState = ADDR;
                        w_nextVcnt  = r_vcnt + 1'b1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        rom_ce    = 1'b0;
        rom_a     = '0;
        out_valid = 1'b0;
        out_voice = '0;
        out_phase = '0;
        out_gate  = 1'b0;
        case (r_state)
            ADDR: begin
                rom_ce = 1'b1;
                rom_a  = r_note[r_vcnt];
            end
            ACC: begin
                out_valid = 1'b1;
                out_voice = r_vcnt;
                out_phase = w_newPhase[PHASE_W-1 -: OUT_W];
                out_gate  = r_gate[r_vcnt];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_vcnt    <= '0;
            r_step    <= '0;
            r_first   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_vcnt  <= w_nextVcnt;
            r_first <= (r_state == ADDR);
            if (r_first) begin
                r_step <= rom_d;
            end
            if (sample_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // The note write comes after the ACC update so a same-cycle retrig wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate <= '0;
            for (int i = 0; i < VOICES; i++) begin
                r_note[i]  <= '0;
                r_phase[i] <= '0;
            end
        end else begin
            if (w_done) begin
                r_phase[r_vcnt] <= w_newPhase;
            end
            if (note_we) begin
                r_note[note_voice] <= note_num;
                r_gate[note_voice] <= note_gate;
                if (note_retrig) begin
                    r_phase[note_voice] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed self-checking bench for nco_phase_acc with a behavioural step-size ROM
// that answers one clock after rom_ce.
module tb_nco_phase_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_tick;
    logic        note_we;
    logic [2:0]  note_voice;
    logic [6:0]  note_num;
    logic        note_gate;
    logic        note_retrig;
    logic        rom_ce;
    logic [6:0]  rom_a;
    logic [15:0] rom_d = '0;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_voice;
    logic [11:0] out_phase;
    logic        out_gate;
    logic        overrun;

    int testsRun    = 0;
    int testsFailed = 0;

    int          nSamp    [8];
    logic [11:0] capPhase [8];
    logic        capGate  [8];
    int          total;
    int          firstValidCyc;
    int          scanLen;
    logic [6:0]  romA0;

    nco_phase_acc #(.VOICES(8), .PHASE_W(24), .OUT_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .note_we(note_we), .note_voice(note_voice), .note_num(note_num),
        .note_gate(note_gate), .note_retrig(note_retrig),
        .rom_ce(rom_ce), .rom_a(rom_a), .rom_d(rom_d),
        .out_valid(out_valid), .out_ready(out_ready), .out_voice(out_voice),
        .out_phase(out_phase), .out_gate(out_gate), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] stepOf(input logic [6:0] note);
        if (note == 7'd69)       return 16'd901;
        else if (note == 7'd127) return 16'd25690;
        else                     return 16'(note) * 16'd300 + 16'd7;
    endfunction

    always @(posedge clk) begin
        if (rom_ce) rom_d <= stepOf(rom_a);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic writeNote(input int v, input int n, input bit g, input bit rt);
        note_we = 1'b1; note_voice = 3'(v); note_num = 7'(n); note_gate = g; note_retrig = rt;
        @(posedge clk); #1;
        note_we = 1'b0; note_retrig = 1'b0;
    endtask

    task automatic applyStimulus(input int stallVoice, input int stallLen, input logic [11:0] expStall,
                                 input int retrigVoice, input bit doubleTick);
        int cyc;
        bit stalled;
        bit wePending;
        cyc = 0; stalled = 0; wePending = 0;
        total = 0; firstValidCyc = -1; scanLen = 0; romA0 = '0;
        for (int v = 0; v < 8; v++) begin
            nSamp[v] = 0; capPhase[v] = '0; capGate[v] = 1'b0;
        end
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        while (total < 8 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (wePending) begin
                note_we = 1'b0; note_retrig = 1'b0; wePending = 0;
            end
            if (doubleTick) sample_tick = (cyc == 3);
            if (rom_ce && cyc == 1) romA0 = rom_a;
            if (out_valid && firstValidCyc < 0) firstValidCyc = cyc;
            if (out_valid && int'(out_voice) == stallVoice && !stalled) begin
                stalled = 1;
                out_ready = 1'b0;
                for (int k = 0; k < stallLen; k++) begin
                    @(negedge clk);
                    cyc++;
                    checkOutput("stallValid", 32'(out_valid), 32'd1);
                    checkOutput("stallVoice", 32'(out_voice), 32'(stallVoice));
                    checkOutput("stallPhase", 32'(out_phase), 32'(expStall));
                    checkOutput("stallGate", 32'(out_gate), 32'd1);
                end
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (int'(out_voice) == retrigVoice) begin
                    note_we = 1'b1; note_voice = out_voice; note_num = 7'd100;
                    note_gate = 1'b1; note_retrig = 1'b1; wePending = 1;
                end
                nSamp[out_voice]++;
                capPhase[out_voice] = out_phase;
                capGate[out_voice]  = out_gate;
                total++;
                scanLen = cyc;
            end
        end
        if (total < 8) checkOutput("scanTimeout", 32'(total), 32'd8);
        @(posedge clk); #1;
        sample_tick = 1'b0;
        if (wePending) begin
            note_we = 1'b0; note_retrig = 1'b0;
        end
    endtask

    initial begin
        int quiet;
        bit hit;
        rst_n = 1'b0; sample_tick = 1'b0; note_we = 1'b0; note_voice = '0;
        note_num = '0; note_gate = 1'b0; note_retrig = 1'b0; out_ready = 1'b1;
        #12;
        checkOutput("rstRomCe", 32'(rom_ce), 32'd0);
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstOverrun", 32'(overrun), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        writeNote(0, 69, 1'b1, 1'b0);
        writeNote(3, 127, 1'b1, 1'b0);

        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("firstValidLatency", 32'(firstValidCyc), 32'd2);
        checkOutput("romAddrVoice0", 32'(romA0), 32'd69);
        checkOutput("scanLength", 32'(scanLen), 32'd16);
        checkOutput("v0Tick1", 32'(capPhase[0]), 32'd0);
        checkOutput("v0Gate", 32'(capGate[0]), 32'd1);
        checkOutput("v3Tick1", 32'(capPhase[3]), 32'd6);
        checkOutput("v1GateOff", 32'(capGate[1]), 32'd0);
        checkOutput("v1PhaseOff", 32'(capPhase[1]), 32'd0);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("v3Tick2", 32'(capPhase[3]), 32'd12);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("v3Tick3", 32'(capPhase[3]), 32'd18);
        checkOutput("v0Tick3", 32'(capPhase[0]), 32'd0);

        for (int s = 4; s <= 654; s++) begin
            applyStimulus(-1, 0, '0, -1, 1'b0);
            if (s == 653) checkOutput("v3BeforeWrap", 32'(capPhase[3]), 32'd4095);
        end
        checkOutput("v3AfterWrap", 32'(capPhase[3]), 32'd5);
        checkOutput("v0Tick654", 32'(capPhase[0]), 32'd143);

        writeNote(2, 60, 1'b1, 1'b0);
        applyStimulus(2, 5, 12'd4, -1, 1'b0);
        checkOutput("stallOneUpdate", 32'(nSamp[2]), 32'd1);
        checkOutput("stallScanTotal", 32'(total), 32'd8);
        checkOutput("stallCapPhase", 32'(capPhase[2]), 32'd4);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("afterStallPhase", 32'(capPhase[2]), 32'd8);

        checkOutput("overrunClear", 32'(overrun), 32'd0);
        applyStimulus(-1, 0, '0, -1, 1'b1);
        checkOutput("overrunSet", 32'(overrun), 32'd1);
        checkOutput("overrunScanTotal", 32'(total), 32'd8);
        checkOutput("overrunV2", 32'(capPhase[2]), 32'd13);
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        checkOutput("noExtraScan", 32'(quiet), 32'd0);
        @(posedge clk); #1;

        writeNote(1, 100, 1'b1, 1'b0);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("v1First", 32'(capPhase[1]), 32'd7);
        applyStimulus(-1, 0, '0, 1, 1'b0);
        checkOutput("v1BeforeRetrig", 32'(capPhase[1]), 32'd14);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("v1AfterRetrig", 32'(capPhase[1]), 32'd7);

        writeNote(3, 127, 1'b0, 1'b0);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("gateOffGate", 32'(capGate[3]), 32'd0);
        checkOutput("gateOffPhase", 32'(capPhase[3]), 32'd0);
        writeNote(3, 127, 1'b1, 1'b0);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("gateOnFromZero", 32'(capPhase[3]), 32'd6);

        writeNote(4, 10, 1'b1, 1'b0);
        sample_tick = 1'b1;
        @(posedge clk); #1;
        sample_tick = 1'b0;
        hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (out_valid && out_voice == 3'd4) hit = 1;
        end
        checkOutput("reachVoice4", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("asyncRstValid", 32'(out_valid), 32'd0);
        checkOutput("asyncRstVoice", 32'(out_voice), 32'd0);
        checkOutput("asyncRstPhase", 32'(out_phase), 32'd0);
        checkOutput("asyncRstGate", 32'(out_gate), 32'd0);
        checkOutput("asyncRstRomCe", 32'(rom_ce), 32'd0);
        checkOutput("asyncRstRomA", 32'(rom_a), 32'd0);
        checkOutput("asyncRstOverrun", 32'(overrun), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        quiet = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        checkOutput("noValidAfterRst", 32'(quiet), 32'd0);
        @(posedge clk); #1;
        writeNote(3, 127, 1'b1, 1'b0);
        applyStimulus(-1, 0, '0, -1, 1'b0);
        checkOutput("postRstV3", 32'(capPhase[3]), 32'd6);
        checkOutput("postRstV4Gate", 32'(capGate[4]), 32'd0);
        checkOutput("postRstScanTotal", 32'(total), 32'd8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
